lsu_ram_ctrl: RTL

- Load/store access stage in front of generic_ram. Accepts RV32 load/store requests from the execute stage over a valid/ready handshake.
- Drives the single-port, word-wide RAM. RAM write is synchronous; RAM read is combinational.
- Sub-word stores use a read-modify-write sequence. Loads are byte/half extracted and sign- or zero-extended.
- Returns a response with data or an error flag to the writeback stage.

---
 rtl/lsu_ram_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ram_ctrl.sv
// lsu_ram_ctrl: load/store access stage in front of a single-port word RAM.
// Accepts RV32 load/store requests over valid/ready, performs read-modify-write
// for sub-word stores, extracts and extends sub-word loads, and returns a
// response holding the load data and an error flag.
//
// Optional build macro: LSU_SW_BYPASS_EN -- a legal SW skips the RAM read and
// goes straight to the write cycle (store-word latency 2 instead of 3).
//
// Ports:
//   clock, reset_n            clock, async active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_funct3        store/load select, RV32 size/sign code
//   req_addr, req_wdata       byte address, right-aligned store data
//   rsp_valid/rsp_ready       response handshake (held until accepted)
//   rsp_rdata, rsp_err        load result (0 for stores/errors), error flag
//   ram_write_en, ram_addr    RAM write strobe and word index
//   ram_wdata, ram_rdata      RAM write data, combinational RAM read data
module lsu_ram_ctrl #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [2:0]                  req_funct3,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  output logic                        ram_write_en,
  output logic [$clog2(DEPTH)-1:0]    ram_addr,
  output logic [31:0]                 ram_wdata,
  input  logic [31:0]                 ram_rdata
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [31:0]         ram_wdata_d;
  logic                ram_write_en_d;
  logic                rsp_valid_d;
  logic [31:0]         rsp_rdata_d;
  logic                rsp_err_d;
  logic                req_bad_c;

  // funct3 legality: loads allow B/H/W/BU/HU, stores allow B/H/W
  function automatic logic f3_ok(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Little-endian lane extraction with sign/zero extension
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return word;
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Replace the addressed byte lanes of the old word with store data
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3[1:0])
      2'b00: begin
        mask = 32'h0000_00ff << {off, 3'b000};
        data = {4{wd[7:0]}};
      end
      2'b01: begin
        mask = 32'h0000_ffff << {off[1], 4'b0000};
        data = {2{wd[15:0]}};
      end
      default: begin
        mask = 32'hffff_ffff;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  assign req_ready = (state_q == S_IDLE);

  // Illegal funct3, misaligned half/word, or word index past the RAM
  always_comb begin
    req_bad_c = !f3_ok(req_we, req_funct3);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_bad_c = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad_c = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DEPTH_W)                req_bad_c = 1'b1;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    f3_d           = f3_q;
    off_d          = off_q;
    wdata_d        = wdata_q;
    ram_addr_d     = ram_addr;
    ram_wdata_d    = ram_wdata;
    ram_write_en_d = 1'b0;
    rsp_valid_d    = rsp_valid;
    rsp_rdata_d    = rsp_rdata;
    rsp_err_d      = rsp_err;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          f3_d       = req_funct3;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          ram_addr_d = req_addr[ADDR_W+1:2];
          if (req_bad_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
`ifdef LSU_SW_BYPASS_EN
            // Full-word store needs no old data
            if (req_we && req_funct3 == 3'b010) begin
              state_d        = S_WRITE;
              ram_wdata_d    = req_wdata;
              ram_write_en_d = 1'b1;
            end else begin
              state_d = S_READ;
            end
`else
            state_d = S_READ;
`endif
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          state_d        = S_WRITE;
          ram_wdata_d    = store_merge(ram_rdata, wdata_q, f3_q, off_q);
          ram_write_en_d = 1'b1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_ext(ram_rdata, f3_q, off_q);
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      ram_addr     <= '0;
      ram_wdata    <= 32'd0;
      ram_write_en <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      ram_addr     <= ram_addr_d;
      ram_wdata    <= ram_wdata_d;
      ram_write_en <= ram_write_en_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_err      <= rsp_err_d;
    end
  end

endmodule
